// File: rtl/pwm_decoder.sv
// PWM receiver: measures period and high time of pwm_in in `step` ticks, once per period.
// Optional macro PWM_DEC_GLITCH_EN adds a 2-tick agreement filter on the sampled level.
module pwm_decoder #(
    parameter int          W       = 16,
    parameter int unsigned TIMEOUT = 2**W - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         step,
    input  logic         pwm_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         stuck,
    output logic         stuck_level,
    output logic         o_dbg_state
);

    typedef enum logic {
        SEEK    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [W-1:0] TO = W'(TIMEOUT);

    logic         r_sync1;
    logic         r_sync2;
    logic         r_lvl;
    logic         r_primed;
    state_t       r_state;
    logic [W-1:0] r_per;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_idle;
    logic         r_valid;
    logic [W-1:0] r_period;
    logic [W-1:0] r_high;
    logic         r_stuck;
    logic         r_stuck_lvl;

    logic         w_new_lvl;
    logic         w_pend_next;
    logic         w_rise;
    logic [W-1:0] w_per_inc;
    logic [W-1:0] w_idle_inc;
    logic [W-1:0] w_hi_inc;

`ifdef PWM_DEC_GLITCH_EN
    logic r_pend;

    // A level change is accepted only when seen on two consecutive primed ticks.
    always_comb begin
        w_new_lvl   = r_sync2;
        w_pend_next = 1'b0;
        if (r_primed) begin
            w_new_lvl = r_lvl;
            if (r_sync2 != r_lvl) begin
                if (r_pend) begin
                    w_new_lvl = r_sync2;
                end else begin
                    w_pend_next = 1'b1;
                end
            end
        end
    end
`else
    assign w_new_lvl   = r_sync2;
    assign w_pend_next = 1'b0;
`endif

    assign w_rise     = step & r_primed & w_new_lvl & ~r_lvl;
    assign w_per_inc  = r_per + 1'b1;
    assign w_idle_inc = r_idle + 1'b1;
    assign w_hi_inc   = r_hi + {{(W-1){1'b0}}, w_new_lvl};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_lvl       <= 1'b0;
            r_primed    <= 1'b0;
            r_state     <= SEEK;
            r_per       <= '0;
            r_hi        <= '0;
            r_idle      <= '0;
            r_valid     <= 1'b0;
            r_period    <= '0;
            r_high      <= '0;
            r_stuck     <= 1'b0;
            r_stuck_lvl <= 1'b0;
`ifdef PWM_DEC_GLITCH_EN
            r_pend      <= 1'b0;
`endif
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            if (!ena) begin
                r_state  <= SEEK;
                r_per    <= '0;
                r_hi     <= '0;
                r_idle   <= '0;
                r_primed <= 1'b0;
`ifdef PWM_DEC_GLITCH_EN
                r_pend   <= 1'b0;
`endif
            end else if (step) begin
                // The unprimed tick only loads the level so its reset value cannot fake an edge.
                r_lvl    <= w_new_lvl;
                r_primed <= 1'b1;
`ifdef PWM_DEC_GLITCH_EN
                r_pend   <= w_pend_next;
`endif
                if (r_primed) begin
                    case (r_state)
                        SEEK: begin
                            if (w_rise) begin
                                r_state <= MEASURE;
                                r_per   <= W'(1);
                                r_hi    <= W'(1);
                                r_idle  <= '0;
                            end else if (w_idle_inc == TO) begin
                                r_valid     <= 1'b1;
                                r_period    <= '0;
                                r_high      <= '0;
                                r_stuck     <= 1'b1;
                                r_stuck_lvl <= w_new_lvl;
                                r_idle      <= '0;
                            end else begin
                                r_idle <= w_idle_inc;
                            end
                        end
                        MEASURE: begin
                            if (w_rise) begin
                                r_valid     <= 1'b1;
                                r_period    <= r_per;
                                r_high      <= r_hi;
                                r_stuck     <= 1'b0;
                                r_stuck_lvl <= w_new_lvl;
                                r_per       <= W'(1);
                                r_hi        <= W'(1);
                            end else if (w_per_inc == TO) begin
                                r_valid     <= 1'b1;
                                r_period    <= '0;
                                r_high      <= '0;
                                r_stuck     <= 1'b1;
                                r_stuck_lvl <= w_new_lvl;
                                r_state     <= SEEK;
                                r_per       <= '0;
                                r_hi        <= '0;
                                r_idle      <= '0;
                            end else begin
                                r_per <= w_per_inc;
                                r_hi  <= w_hi_inc;
                            end
                        end
                        default: r_state <= SEEK;
                    endcase
                end
            end
        end
    end

    assign period      = r_period;
    assign high_time   = r_high;
    assign valid       = r_valid;
    assign stuck       = r_stuck;
    assign stuck_level = r_stuck_lvl;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: expected reports are queued as waveforms are driven
// and checked by a monitor whenever valid pulses.
module tb_pwm_decoder;

    localparam int W  = 16;
    localparam int TO = 20;
    localparam int EW = 2*W + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         step;
    logic         pwm_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         stuck;
    logic         stuck_level;
    logic         dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    int div    = 1;

    // {check_level, stuck, stuck_level, period, high_time}
    logic [EW-1:0] exp_q[$];

    pwm_decoder #(.W(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .step        (step),
        .pwm_in      (pwm_in),
        .period      (period),
        .high_time   (high_time),
        .valid       (valid),
        .stuck       (stuck),
        .stuck_level (stuck_level),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic chk_lvl, input logic st, input logic lv,
                        input logic [W-1:0] per, input logic [W-1:0] hi);
        exp_q.push_back({chk_lvl, st, lv, per, hi});
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        pwm_in = 1'b0;
        rst    = 1'b1;
        clks(2);
        rst    = 1'b0;
    endtask

    task automatic periods(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            clks(hi);
            pwm_in = 1'b0;
            clks(lo);
        end
    endtask

    task automatic drain(input string tag);
        check(tag, 16'(exp_q.size()), 16'd0);
        exp_q.delete();
    endtask

    // Closing rise completes the last period; hold it long enough for the report.
    task automatic close_phase(input string tag, input int hold);
        pwm_in = 1'b1;
        clks(hold);
        drain(tag);
        do_reset();
    endtask

    // step generator: one tick every `div` clocks
    initial begin
        int c;
        c    = 0;
        step = 1'b0;
        forever begin
            @(negedge clk);
            c++;
            if (c >= div) c = 0;
            step = (c == 0);
        end
    end

    // scoreboard monitor
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                check("unexpected_valid", (exp_q.size() != 0) ? 16'd1 : 16'd0, 16'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("period", period, e[2*W-1:W]);
                    check("high_time", high_time, e[W-1:0]);
                    check("stuck", 16'(stuck), 16'(e[2*W+1]));
                    if (e[2*W+2]) check("stuck_level", 16'(stuck_level), 16'(e[2*W]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        pwm_in = 1'b0;
        div    = 1;
        clks(3);
        check("rst_period", period, 16'd0);
        check("rst_high_time", high_time, 16'd0);
        check("rst_valid", 16'(valid), 16'd0);
        check("rst_stuck", 16'(stuck), 16'd0);
        check("rst_stuck_level", 16'(stuck_level), 16'd0);
        rst = 1'b0;
        clks(4);

        // 3 high / 5 low, step every clock
        for (int i = 0; i < 5; i++) push(1'b0, 1'b0, 1'b0, 16'd8, 16'd3);
        periods(3, 5, 5);
        close_phase("drain_basic", 6);

        // step every 4th clock, 12 high / 20 low clocks
        div = 4;
        clks(8);
        for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b0, 16'd8, 16'd3);
        periods(12, 20, 4);
        close_phase("drain_div4", 12);

        // held high: stuck reports every TIMEOUT ticks
        div    = 1;
        pwm_in = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 1'b1, 16'd0, 16'd0);
        clks(70);
        drain("drain_stuck_hi");
        do_reset();

        // held low
        for (int i = 0; i < 2; i++) push(1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
        clks(50);
        drain("drain_stuck_lo");
        do_reset();

        // reset in the middle of a high phase
        clks(4);
        push(1'b0, 1'b0, 1'b0, 16'd8, 16'd3);
        periods(3, 5, 1);
        pwm_in = 1'b1;
        clks(5);
        drain("drain_pre_rst");
        rst = 1'b1;
        clks(1);
        rst    = 1'b0;
        pwm_in = 1'b0;
        check("mrst_period", period, 16'd0);
        check("mrst_high_time", high_time, 16'd0);
        check("mrst_valid", 16'(valid), 16'd0);
        check("mrst_stuck", 16'(stuck), 16'd0);
        clks(5);
        for (int i = 0; i < 2; i++) push(1'b0, 1'b0, 1'b0, 16'd8, 16'd3);
        periods(3, 5, 2);
        close_phase("drain_mrst", 6);

        // ena dropped for 10 clocks mid-period
        clks(4);
        push(1'b0, 1'b0, 1'b0, 16'd8, 16'd3);
        periods(3, 5, 1);
        pwm_in = 1'b1;
        clks(3);
        pwm_in = 1'b0;
        clks(2);
        ena = 1'b0;
        clks(10);
        ena = 1'b1;
        check("ena_hold_period", period, 16'd8);
        check("ena_hold_high_time", high_time, 16'd3);
        clks(3);
        for (int i = 0; i < 2; i++) push(1'b0, 1'b0, 1'b0, 16'd8, 16'd3);
        periods(3, 5, 2);
        close_phase("drain_ena", 6);

        // one-tick glitch inside the low phase
        clks(4);
        for (int i = 0; i < 3; i++) begin
`ifdef PWM_DEC_GLITCH_EN
            push(1'b0, 1'b0, 1'b0, 16'd8, 16'd3);
`else
            push(1'b0, 1'b0, 1'b0, 16'd5, 16'd3);
            push(1'b0, 1'b0, 1'b0, 16'd3, 16'd1);
`endif
        end
        for (int i = 0; i < 3; i++) begin
            pwm_in = 1'b1;
            clks(3);
            pwm_in = 1'b0;
            clks(2);
            pwm_in = 1'b1;
            clks(1);
            pwm_in = 1'b0;
            clks(2);
        end
        close_phase("drain_glitch", 6);

        clks(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
